// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory subsystem.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 16;

    // One-hot grant vector for a port ID.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
module rr_arbiter2
    import lc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone request wins outright; on a tie the port that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = port_onehot(PORT_CPU);
            2'b10:   grant = port_onehot(PORT_DMA);
            2'b11:   grant = port_onehot(~last_grant);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one RAM between the CPU port (0) and the loader/DMA port (1).
module ram_access_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_in_data,
    input  logic [DATA_WIDTH-1:0] ram_out_data,
    output logic [1:0]            grant
);

    localparam int               CNT_W     = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RAM_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [1:0]            pick, grant_d;
    logic                  ram_read_d, ram_write_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [DATA_WIDTH-1:0] ram_in_data_d;
    logic                  p0_ack_d, p1_ack_d;
    logic [DATA_WIDTH-1:0] p0_rdata_d, p1_rdata_d;
    logic                  sel_port, sel_write, owner;

    rr_arbiter2 u_rr (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    // State and every output are registers; reset aborts any transfer without an ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_DMA;
            wait_cnt_q   <= '0;
            grant        <= 2'b00;
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            ram_address  <= '0;
            ram_in_data  <= '0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            grant        <= grant_d;
            ram_read     <= ram_read_d;
            ram_write    <= ram_write_d;
            ram_address  <= ram_address_d;
            ram_in_data  <= ram_in_data_d;
            p0_ack       <= p0_ack_d;
            p1_ack       <= p1_ack_d;
            p0_rdata     <= p0_rdata_d;
            p1_rdata     <= p1_rdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, pulse the strobe once, wait out the RAM, ack.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_cnt_d    = wait_cnt_q;
        grant_d       = grant;
        ram_read_d    = ram_read;
        ram_write_d   = ram_write;
        ram_address_d = ram_address;
        ram_in_data_d = ram_in_data;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p0_rdata_d    = p0_rdata;
        p1_rdata_d    = p1_rdata;
        sel_port      = pick[1] ? PORT_DMA : PORT_CPU;
        sel_write     = sel_port ? p1_write : p0_write;
        owner         = grant[1] ? PORT_DMA : PORT_CPU;

        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    grant_d       = pick;
                    last_grant_d  = sel_port;
                    ram_address_d = sel_port ? p1_addr : p0_addr;
                    ram_in_data_d = sel_port ? p1_wdata : p0_wdata;
                    ram_write_d   = sel_write;
                    ram_read_d    = ~sel_write;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_read_d  = 1'b0;
                ram_write_d = 1'b0;
                if (ram_write) begin
                    p0_ack_d = (owner == PORT_CPU);
                    p1_ack_d = (owner == PORT_DMA);
                    state_d  = ST_DONE;
                end else begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    if (owner == PORT_DMA) begin
                        p1_rdata_d = ram_out_data;
                        p1_ack_d   = 1'b1;
                    end else begin
                        p0_rdata_d = ram_out_data;
                        p0_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
